// File: rtl/fp2dec_sched.sv
// rtl/fp2dec_sched.sv - two-requester scheduler for an IEEE754-to-decimal converter
// Grants one requester at a time, filters special exponents, and aborts a stalled converter.
module fp2dec_sched #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] fp0,
  input  logic [31:0] fp1,
  output logic        ack0,
  output logic        ack1,
  output logic [4:0]  res_nguyen,
  output logic [19:0] res_le,
  output logic [8:0]  res_lt,
  output logic        res_sign,
  output logic        res_err,
  output logic        res_id,
  output logic        conv_start,
  output logic [31:0] conv_in,
  output logic        conv_rst,
  input  logic        conv_done,
  input  logic [4:0]  conv_nguyen,
  input  logic [19:0] conv_le,
  input  logic [8:0]  conv_lt,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [TW-1:0]  cnt;
  logic           prio;
  logic           gnt;
  logic           gnt_id;
  logic [31:0]    gnt_fp;
  logic [7:0]     gnt_exp;
  logic           done_hit;
  logic           timeout_hit;
  logic           resp_id;

  always_comb begin
    next_state  = state;
    gnt         = 1'b0;
    gnt_id      = 1'b0;
    gnt_fp      = fp0;
    gnt_exp     = 8'd0;
    done_hit    = (state == WAIT) && conv_done;
    timeout_hit = (state == WAIT) && !conv_done && (cnt == TW'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt     = 1'b1;
          gnt_id  = (req0 && req1) ? prio : req1;
          gnt_fp  = gnt_id ? fp1 : fp0;
          gnt_exp = gnt_fp[30:23];
          // zero and Inf/NaN exponents are answered without the converter
          if (gnt_exp == 8'hFF || gnt_exp == 8'h00) next_state = RESP;
          else                                       next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (done_hit || timeout_hit) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    resp_id = gnt ? gnt_id : res_id;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      prio       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      res_nguyen <= '0;
      res_le     <= '0;
      res_lt     <= '0;
      res_sign   <= 1'b0;
      res_err    <= 1'b0;
      res_id     <= 1'b0;
      conv_start <= 1'b0;
      conv_in    <= '0;
      conv_rst   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != IDLE);
      conv_start <= (state == IDLE) && (next_state == ISSUE);
      conv_rst   <= timeout_hit;
      ack0       <= (next_state == RESP) && !resp_id;
      ack1       <= (next_state == RESP) && resp_id;

      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + TW'(1);

      if (gnt) begin
        conv_in  <= gnt_fp;
        res_id   <= gnt_id;
        res_sign <= gnt_fp[31];
      end

      if (gnt && next_state == RESP) begin
        res_nguyen <= '0;
        res_le     <= '0;
        res_lt     <= '0;
        res_err    <= (gnt_exp == 8'hFF);
      end else if (done_hit) begin
        res_nguyen <= conv_nguyen;
        res_le     <= conv_le;
        res_lt     <= conv_lt;
        res_err    <= 1'b0;
      end else if (timeout_hit) begin
        res_nguyen <= '0;
        res_le     <= '0;
        res_lt     <= '0;
        res_err    <= 1'b1;
      end

      // the requester just served loses the next tie
      if (state == RESP) prio <= ~res_id;
    end
  end

endmodule
